ddr_axi0_responder: RTL and testbench

DDR_AXI0_RESPONDER -- requirements
Module: ddr_axi0_responder
Interface
REQ-001 Parameter MEM_AW, default 6, log2 of memory depth in 256-bit words (64 words).
REQ-002 Axi0Clk  in  1  sole clock; all logic on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 DdrCtrl_AID_0  in  8  address-phase transaction ID.
REQ-005 DdrCtrl_AADDR_0  in  32  byte address; word index = AADDR[MEM_AW+4:5].
REQ-006 DdrCtrl_ALEN_0  in  8  burst length minus one.
REQ-007 DdrCtrl_ABURST_0  in  2  burst type; only 2'b01 (INCR) is legal.
REQ-008 DdrCtrl_AVALID_0  in  1  address valid.
REQ-009 DdrCtrl_AREADY_0  out  1  address ready.
REQ-010 DdrCtrl_ATYPE_0  in  1  1=write, 0=read.
REQ-011 DdrCtrl_WDATA_0  in  256  write data.
REQ-012 DdrCtrl_WSTRB_0  in  32  byte enables; bit i enables WDATA[8i+7:8i].
REQ-013 DdrCtrl_WLAST_0  in  1  last write beat.
REQ-014 DdrCtrl_WVALID_0  in  1  write data valid.
REQ-015 DdrCtrl_WREADY_0  out  1  write data ready.
REQ-016 DdrCtrl_RID_0  out  8  read ID, equals captured AID.
REQ-017 DdrCtrl_RDATA_0  out  256  read data.
REQ-018 DdrCtrl_RLAST_0  out  1  last read beat.
REQ-019 DdrCtrl_RVALID_0  out  1  read data valid.
REQ-020 DdrCtrl_RREADY_0  in  1  read data ready.
REQ-021 DdrCtrl_RRESP_0  out  2  read response; constant 2'b00.
REQ-022 DdrCtrl_BID_0  out  8  write response ID, equals captured AID.
REQ-023 DdrCtrl_BVALID_0  out  1  write response valid.
REQ-024 DdrCtrl_BREADY_0  in  1  write response ready.
REQ-025 busy  out  1  high in any state other than IDLE.
REQ-026 err  out  1  sticky protocol-error flag.
Function
REQ-027 FSM states: IDLE, WDATA, WRESP, RDATA; one transaction in flight at a time; no address queuing.
REQ-028 IDLE: AREADY=1; on AVALID&AREADY, capture AID/word index/ALEN, clear beat counter, go to WDATA if ATYPE=1, else RDATA; AREADY=0 in all other states.
REQ-029 Word address increments by 1 per accepted beat, wrapping modulo 2^MEM_AW; AADDR[4:0]≠0 or ABURST≠2'b01 sets err, and the transfer still proceeds as INCR from the truncated index.
REQ-030 WDATA: WREADY=1; each WVALID&WREADY beat writes only strobed bytes to the current word; beats after beat ALEN are accepted but discarded.
REQ-031 WLAST on a beat other than ALEN, or a missing WLAST on beat ALEN, sets err; the FSM leaves WDATA only on an accepted WLAST beat, then enters WRESP.
REQ-032 WRESP: BVALID=1, BID=captured AID; on BREADY return to IDLE; BVALID stays high and BID stays stable until BREADY.
REQ-033 RDATA: memory read is registered; first RVALID appears 2 cycles after the address handshake cycle (handshake at N, RVALID at N+2).
REQ-034 While RVALID=1 and RREADY=0, RDATA/RLAST/RID hold stable; the next beat is presented the cycle after each accepted beat (full throughput with RREADY held high).
REQ-035 RLAST=1 only on beat ALEN; after that beat is accepted, RVALID drops and the FSM returns to IDLE on the following edge.
REQ-036 A write followed by a read of the same word returns the written data (no stale read); ALEN=0 gives a single beat with WLAST/RLAST on beat 0.
Reset
REQ-037 rst_n low forces IDLE and AREADY/WREADY/RVALID/RLAST/BVALID/busy/err=0, RID/BID/RDATA=0, immediately and regardless of clock; memory contents are not reset.
REQ-038 AREADY rises on the first clock edge after rst_n deasserts; reset mid-burst aborts the burst without a B or R completion.
Verification
REQ-039 Write AADDR=0x40, ALEN=3, WSTRB all-ones, data 0xA0..0xA3; read back -> 4 beats A0..A3, RLAST on beat 3, RID=AID, BID=AID, err=0.
REQ-040 Write word 2 with WSTRB=0x0000000F over word preloaded with all-ones -> readback has only low 4 bytes changed.
REQ-041 Read ALEN=7 with RREADY toggled 1/0 -> data stays stable while RREADY=0, 8 beats in order, busy low after the last beat.
REQ-042 Write with WLAST on beat 1 of ALEN=3 -> err=1, BVALID issued, word index 2 not written.
REQ-043 Burst from word 62, ALEN=3 (MEM_AW=6) -> words 62,63,0,1 written/read.
REQ-044 rst_n pulsed low during RDATA beat 2 -> RVALID=0 same cycle, AREADY=1 the cycle after release, next write completes normally.

---
 rtl/ddr_axi0_responder.sv | 189 ++++++++++++++++++
 tb/tb_ddr_axi0_responder.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_axi0_responder.sv
// ddr_axi0_responder: single-outstanding AXI-like slave in front of a
// 256-bit-wide on-chip memory. It accepts one address phase at a time,
// then either absorbs a write burst (byte-strobed) and returns a write
// response, or streams a read burst with a one-cycle registered memory read.
module ddr_axi0_responder #(
  parameter int MEM_AW = 6
) (
  input  logic         Axi0Clk,
  input  logic         rst_n,
  input  logic [7:0]   DdrCtrl_AID_0,
  input  logic [31:0]  DdrCtrl_AADDR_0,
  input  logic [7:0]   DdrCtrl_ALEN_0,
  input  logic [1:0]   DdrCtrl_ABURST_0,
  input  logic         DdrCtrl_AVALID_0,
  output logic         DdrCtrl_AREADY_0,
  input  logic         DdrCtrl_ATYPE_0,
  input  logic [255:0] DdrCtrl_WDATA_0,
  input  logic [31:0]  DdrCtrl_WSTRB_0,
  input  logic         DdrCtrl_WLAST_0,
  input  logic         DdrCtrl_WVALID_0,
  output logic         DdrCtrl_WREADY_0,
  output logic [7:0]   DdrCtrl_RID_0,
  output logic [255:0] DdrCtrl_RDATA_0,
  output logic         DdrCtrl_RLAST_0,
  output logic         DdrCtrl_RVALID_0,
  input  logic         DdrCtrl_RREADY_0,
  output logic [1:0]   DdrCtrl_RRESP_0,
  output logic [7:0]   DdrCtrl_BID_0,
  output logic         DdrCtrl_BVALID_0,
  input  logic         DdrCtrl_BREADY_0,
  output logic         busy,
  output logic         err
);

  localparam int DEPTH = 1 << MEM_AW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WDATA,
    S_WRESP,
    S_RDATA
  } state_t;

  state_t              state_q;
  logic [255:0]        mem [DEPTH];
  logic [MEM_AW-1:0]   addr_q;
  logic [MEM_AW-1:0]   addr_plus1;
  logic [7:0]          id_q;
  logic [7:0]          len_q;
  logic [7:0]          beat_q;
  logic                over_q;    // beat ALEN already consumed; extra beats are dropped
  logic                aready_q;
  logic                wready_q;
  logic                bvalid_q;
  logic                rvalid_q;
  logic                rlast_q;
  logic [255:0]        rdata_q;
  logic                err_q;
  logic                a_hs;
  logic                w_hs;
  logic                wr_en;
  logic                w_proto_bad;
  logic                unused_addr_bits;

  assign a_hs       = DdrCtrl_AVALID_0 & aready_q;
  assign w_hs       = DdrCtrl_WVALID_0 & wready_q;
  assign wr_en      = w_hs & ~over_q;
  assign addr_plus1 = addr_q + 1'b1;   // natural wrap modulo DEPTH

  // WLAST must coincide exactly with beat ALEN; anything else is a protocol error
  assign w_proto_bad = DdrCtrl_WLAST_0 ? (over_q || (beat_q != len_q))
                                       : (!over_q && (beat_q == len_q));

  // Address bits above the memory index are ignored
  assign unused_addr_bits = ^DdrCtrl_AADDR_0[31:MEM_AW+5];

  assign DdrCtrl_AREADY_0 = aready_q;
  assign DdrCtrl_WREADY_0 = wready_q;
  assign DdrCtrl_BVALID_0 = bvalid_q;
  assign DdrCtrl_BID_0    = id_q;
  assign DdrCtrl_RID_0    = id_q;
  assign DdrCtrl_RVALID_0 = rvalid_q;
  assign DdrCtrl_RLAST_0  = rlast_q;
  assign DdrCtrl_RDATA_0  = rdata_q;
  assign DdrCtrl_RRESP_0  = 2'b00;
  assign busy             = (state_q != S_IDLE);
  assign err              = err_q;

  // Byte-strobed write port into the storage array
  // NOTE: the storage array has no reset; clearing it would turn RAM into a huge flop bank, and its contents must survive rst_n anyway.
  always_ff @(posedge Axi0Clk) begin
    if (wr_en) begin
      for (int i = 0; i < 32; i++) begin
        if (DdrCtrl_WSTRB_0[i]) mem[addr_q][8*i +: 8] <= DdrCtrl_WDATA_0[8*i +: 8];
      end
    end
  end

  // Transaction FSM with registered handshake outputs and registered read data
  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values, e.g. rdata reads the old addr_q.
  always_ff @(posedge Axi0Clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      id_q     <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      over_q   <= 1'b0;
      aready_q <= 1'b0;
      wready_q <= 1'b0;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          aready_q <= 1'b1;
          if (a_hs) begin
            aready_q <= 1'b0;
            id_q     <= DdrCtrl_AID_0;
            addr_q   <= DdrCtrl_AADDR_0[MEM_AW+4:5];
            len_q    <= DdrCtrl_ALEN_0;
            beat_q   <= '0;
            over_q   <= 1'b0;
            // Misaligned or non-INCR requests are flagged but still run as INCR
            if ((DdrCtrl_AADDR_0[4:0] != 5'd0) || (DdrCtrl_ABURST_0 != 2'b01)) err_q <= 1'b1;
            if (DdrCtrl_ATYPE_0) begin
              state_q  <= S_WDATA;
              wready_q <= 1'b1;
            end else begin
              state_q  <= S_RDATA;
            end
          end
        end

        S_WDATA: begin
          if (w_hs) begin
            if (w_proto_bad) err_q <= 1'b1;
            if (!over_q) begin
              addr_q <= addr_plus1;
              if (beat_q == len_q) over_q <= 1'b1;
              else                 beat_q <= beat_q + 8'd1;
            end
            if (DdrCtrl_WLAST_0) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              state_q  <= S_WRESP;
            end
          end
        end

        S_WRESP: begin
          if (DdrCtrl_BREADY_0) begin
            bvalid_q <= 1'b0;
            aready_q <= 1'b1;
            state_q  <= S_IDLE;
          end
        end

        S_RDATA: begin
          if (!rvalid_q) begin
            // First beat: one registered read after entering RDATA
            rdata_q  <= mem[addr_q];
            rvalid_q <= 1'b1;
            rlast_q  <= (beat_q == len_q);
          end else if (DdrCtrl_RREADY_0) begin
            if (rlast_q) begin
              rvalid_q <= 1'b0;
              rlast_q  <= 1'b0;
              aready_q <= 1'b1;
              state_q  <= S_IDLE;
            end else begin
              // Prefetch the next word on the accepting edge for full throughput
              addr_q  <= addr_plus1;
              beat_q  <= beat_q + 8'd1;
              rdata_q <= mem[addr_plus1];
              rlast_q <= ((beat_q + 8'd1) == len_q);
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_axi0_responder.sv
// Testbench for ddr_axi0_responder: directed bursts; expected R beats and
// B responses are queued at issue time and checked by an independent monitor.
module tb_ddr_axi0_responder;

  logic         Axi0Clk = 1'b0;
  logic         rst_n;
  logic [7:0]   aid;
  logic [31:0]  aaddr;
  logic [7:0]   alen;
  logic [1:0]   aburst;
  logic         avalid;
  logic         aready;
  logic         atype;
  logic [255:0] wdata;
  logic [31:0]  wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic [7:0]   rid;
  logic [255:0] rdata;
  logic         rlast;
  logic         rvalid;
  logic         rready;
  logic [1:0]   rresp;
  logic [7:0]   bid;
  logic         bvalid;
  logic         bready;
  logic         busy;
  logic         err;

  always #5 Axi0Clk = ~Axi0Clk;

  ddr_axi0_responder #(.MEM_AW(6)) dut (
    .Axi0Clk          (Axi0Clk),
    .rst_n            (rst_n),
    .DdrCtrl_AID_0    (aid),
    .DdrCtrl_AADDR_0  (aaddr),
    .DdrCtrl_ALEN_0   (alen),
    .DdrCtrl_ABURST_0 (aburst),
    .DdrCtrl_AVALID_0 (avalid),
    .DdrCtrl_AREADY_0 (aready),
    .DdrCtrl_ATYPE_0  (atype),
    .DdrCtrl_WDATA_0  (wdata),
    .DdrCtrl_WSTRB_0  (wstrb),
    .DdrCtrl_WLAST_0  (wlast),
    .DdrCtrl_WVALID_0 (wvalid),
    .DdrCtrl_WREADY_0 (wready),
    .DdrCtrl_RID_0    (rid),
    .DdrCtrl_RDATA_0  (rdata),
    .DdrCtrl_RLAST_0  (rlast),
    .DdrCtrl_RVALID_0 (rvalid),
    .DdrCtrl_RREADY_0 (rready),
    .DdrCtrl_RRESP_0  (rresp),
    .DdrCtrl_BID_0    (bid),
    .DdrCtrl_BVALID_0 (bvalid),
    .DdrCtrl_BREADY_0 (bready),
    .busy             (busy),
    .err              (err)
  );

  typedef struct {
    logic [255:0] data;
    logic         last;
    logic [7:0]   id;
  } rexp_t;

  rexp_t        rq[$];
  logic [7:0]   bq[$];
  logic [255:0] model [64];
  int           n_checks = 0;
  int           n_err    = 0;
  int           r_got    = 0;
  int           b_got    = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [255:0] pat(input logic [7:0] b);
    return {32{b}};
  endfunction

  // Monitor: pops the scoreboard on every R/B handshake, and checks R hold under stall
  logic         stall_q = 1'b0;
  logic [255:0] p_data;
  logic         p_last;
  logic [7:0]   p_id;
  rexp_t        e;
  logic [7:0]   eb;
  always @(negedge Axi0Clk) begin
    if (rst_n) begin
      if (stall_q) begin
        check("r_hold_valid", rvalid, 1'b1);
        check("r_hold_data", rdata, p_data);
        check("r_hold_last", rlast, p_last);
        check("r_hold_id", rid, p_id);
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) begin
          check("r_unexpected", 1'b1, 1'b0);
        end else begin
          e = rq.pop_front();
          check("r_data", rdata, e.data);
          check("r_last", rlast, e.last);
          check("r_id", rid, e.id);
          check("r_resp", rresp, 2'b00);
        end
        r_got++;
      end
      if (bvalid && bready) begin
        if (bq.size() == 0) begin
          check("b_unexpected", 1'b1, 1'b0);
        end else begin
          eb = bq.pop_front();
          check("b_id", bid, eb);
        end
        b_got++;
      end
      stall_q = rvalid && !rready;
      p_data  = rdata;
      p_last  = rlast;
      p_id    = rid;
    end else begin
      stall_q = 1'b0;
    end
  end

  // Wait (bounded) for AREADY or WREADY, then let the handshake edge pass
  task automatic wait_hs(input bit is_w);
    bit ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge Axi0Clk);
      if (is_w ? wready : aready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check(is_w ? "w_hs_timeout" : "a_hs_timeout", 1'b0, 1'b1);
    @(posedge Axi0Clk);
    #1;
  endtask

  task automatic addr_phase(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic typ);
    aid = id; aaddr = addr; alen = len; aburst = 2'b01; atype = typ; avalid = 1'b1;
    wait_hs(1'b0);
    avalid = 1'b0;
  endtask

  // Write burst; last_beat is the beat carrying WLAST; bdelay holds BREADY low first
  task automatic write_burst(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [7:0] base, input logic [31:0] strb,
                             input int last_beat, input int bdelay);
    int start;
    int w;
    bq.push_back(id);
    addr_phase(id, addr, len, 1'b1);
    for (int i = 0; i <= last_beat; i++) begin
      wvalid = 1'b1;
      wdata  = pat(base + 8'(i));
      wstrb  = strb;
      wlast  = (i == last_beat);
      if (i <= int'(len)) begin
        w = (int'(addr[10:5]) + i) % 64;
        for (int k = 0; k < 32; k++) if (strb[k]) model[w][8*k +: 8] = base + 8'(i);
      end
      wait_hs(1'b1);
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    for (int d = 0; d < bdelay; d++) begin
      check("b_hold_valid", bvalid, 1'b1);
      check("b_hold_id", bid, id);
      @(posedge Axi0Clk);
      #1;
    end
    start  = b_got;
    bready = 1'b1;
    for (int c = 0; c < 50 && b_got == start; c++) begin
      @(posedge Axi0Clk);
      #1;
    end
    check("b_count", 32'(b_got - start), 32'd1);
    bready = 1'b0;
  endtask

  // Read burst; toggle alternates RREADY, chk_lat checks RVALID at N+1 / N+2
  task automatic read_burst(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input bit toggle, input bit chk_lat);
    int    start;
    int    n;
    rexp_t x;
    n     = int'(len) + 1;
    start = r_got;
    for (int i = 0; i < n; i++) begin
      x.data = model[(int'(addr[10:5]) + i) % 64];
      x.last = (i == n - 1);
      x.id   = id;
      rq.push_back(x);
    end
    rready = 1'b1;
    addr_phase(id, addr, len, 1'b0);
    if (chk_lat) begin
      check("r_lat_n1", rvalid, 1'b0);
      @(posedge Axi0Clk);
      #1;
      check("r_lat_n2", rvalid, 1'b1);
    end
    for (int c = 0; c < 200 && (r_got - start) < n; c++) begin
      @(posedge Axi0Clk);
      #1;
      if (toggle) rready = ~rready;
    end
    check("r_count", 32'(r_got - start), 32'(n));
    check("busy_after_r", busy, 1'b0);
    check("rvalid_after_r", rvalid, 1'b0);
    rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    aid = '0; aaddr = '0; alen = '0; aburst = 2'b01; avalid = 1'b0; atype = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; rready = 1'b0; bready = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_aready", aready, 1'b0);
    check("rst_wready", wready, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_rlast", rlast, 1'b0);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_rid", rid, 8'h00);
    check("rst_bid", bid, 8'h00);
    check("rst_rdata", rdata, 256'h0);
    repeat (3) @(posedge Axi0Clk);
    #1 rst_n = 1'b1;
    check("aready_pre_edge", aready, 1'b0);
    @(posedge Axi0Clk);
    #1;
    check("aready_first_edge", aready, 1'b1);

    // 4-beat write of A0..A3 at word 2, read back with latency check
    write_burst(8'h11, 32'h0000_0040, 8'd3, 8'hA0, 32'hFFFF_FFFF, 3, 2);
    read_burst(8'h22, 32'h0000_0040, 8'd3, 1'b0, 1'b1);
    check("err_clean", err, 1'b0);

    // Fill words 6..9, then 8-beat read of words 2..9 with RREADY toggling
    write_burst(8'h33, 32'h0000_00C0, 8'd3, 8'hB4, 32'hFFFF_FFFF, 3, 0);
    read_burst(8'h44, 32'h0000_0040, 8'd7, 1'b1, 1'b0);

    // Partial strobe over all-ones word 2: only the low four bytes change
    write_burst(8'h55, 32'h0000_0040, 8'd0, 8'hFF, 32'hFFFF_FFFF, 0, 0);
    write_burst(8'h56, 32'h0000_0040, 8'd0, 8'hC5, 32'h0000_000F, 0, 0);
    read_burst(8'h57, 32'h0000_0040, 8'd0, 1'b0, 1'b0);

    // Wrap: words 62,63,0,1
    write_burst(8'h60, 32'h0000_07C0, 8'd3, 8'hD0, 32'hFFFF_FFFF, 3, 0);
    read_burst(8'h61, 32'h0000_07C0, 8'd3, 1'b0, 1'b0);
    read_burst(8'h62, 32'h0000_0000, 8'd1, 1'b0, 1'b0);
    check("err_after_wrap", err, 1'b0);

    // Early WLAST on beat 1 of a 4-beat write from word 0: err, word 2 untouched
    write_burst(8'h70, 32'h0000_0000, 8'd3, 8'hE0, 32'hFFFF_FFFF, 1, 0);
    check("err_early_wlast", err, 1'b1);
    read_burst(8'h71, 32'h0000_0040, 8'd0, 1'b0, 1'b0);

    // Reset while beat 2 of an 8-beat read is presented
    start = r_got;
    for (int i = 0; i < 2; i++) begin
      rq.push_back('{data: model[2 + i], last: 1'b0, id: 8'h80});
    end
    rready = 1'b1;
    addr_phase(8'h80, 32'h0000_0040, 8'd7, 1'b0);
    for (int c = 0; c < 50 && (r_got - start) < 2; c++) begin
      @(posedge Axi0Clk);
      #1;
    end
    check("mid_r_count", 32'(r_got - start), 32'd2);
    check("mid_r_valid", rvalid, 1'b1);
    rready = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("mid_rst_rvalid", rvalid, 1'b0);
    check("mid_rst_rdata", rdata, 256'h0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_err", err, 1'b0);
    check("mid_rst_aready", aready, 1'b0);
    rq.delete();
    @(posedge Axi0Clk);
    #1 rst_n = 1'b1;
    @(posedge Axi0Clk);
    #1;
    check("aready_after_mid_rst", aready, 1'b1);
    write_burst(8'h90, 32'h0000_0100, 8'd1, 8'h5A, 32'hFFFF_FFFF, 1, 0);
    read_burst(8'h91, 32'h0000_0100, 8'd1, 1'b0, 1'b0);
    check("err_post_rst", err, 1'b0);

    repeat (2) @(posedge Axi0Clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
